// File: rtl/ccd_emu_pkg.sv
// Shared definitions for the linear-CCD + AFE emulator.
// Holds pattern encodings, FSM states and TCD1209D line geometry defaults.
// Also provides the PRBS16 next-state helper used by the pattern generator.
package ccd_emu_pkg;

  typedef enum logic [1:0] {
    PAT_RAMP  = 2'd0,
    PAT_CONST = 2'd1,
    PAT_ALT   = 2'd2,
    PAT_PRBS  = 2'd3
  } pat_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INTEG = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // TCD1209D line geometry; the total matches the driver's f_cnt.
  localparam int TCD_PIX_NUM     = 2048;
  localparam int TCD_DUMMY_LEAD  = 32;
  localparam int TCD_DUMMY_TRAIL = 22;
  localparam int TCD_TOTAL       = TCD_DUMMY_LEAD + TCD_PIX_NUM + TCD_DUMMY_TRAIL;

  // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting right; taps land on bits 0,2,3,5.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/ccd_pattern_gen.sv
// Active-pixel test pattern source (ramp / constant / alternating / PRBS16).
// Latency: combinational from pix_idx to pix_val; pattern and LFSR are registered.
// Backpressure: none; the LFSR advances only when step is asserted.
// Ports: pattern_sel/const_val select the pattern, pix_idx is the active pixel
// offset, step advances the PRBS, reload latches pattern_sel and reseeds the LFSR.
module ccd_pattern_gen
  import ccd_emu_pkg::*;
#(
  parameter int              D_WIDTH   = 12,
  parameter int              IDX_W     = 12,
  parameter logic [15:0]     LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [1:0]         pattern_sel,
  input  logic [D_WIDTH-1:0] const_val,
  input  logic [IDX_W-1:0]   pix_idx,
  input  logic               step,
  input  logic               reload,
  output logic [D_WIDTH-1:0] pix_val
);

  pat_e        pat_q;
  logic [15:0] lfsr_q;

  // Pattern is frozen for the whole line so a mid-line change waits for the next line.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pat_q  <= PAT_RAMP;
      lfsr_q <= LFSR_SEED;
    end else if (reload) begin
      pat_q  <= pat_e'(pattern_sel);
      lfsr_q <= LFSR_SEED;
    end else if (step) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  always_comb begin
    pix_val = D_WIDTH'(pix_idx);
    case (pat_q)
      PAT_RAMP:  pix_val = D_WIDTH'(pix_idx);
      PAT_CONST: pix_val = const_val;
      PAT_ALT:   pix_val = pix_idx[0] ? ~const_val : const_val;
      PAT_PRBS:  pix_val = lfsr_q[D_WIDTH-1:0];
      default:   pix_val = D_WIDTH'(pix_idx);
    endcase
  end

endmodule

// File: rtl/ccd_line_emulator.sv
// Linear CCD + AFE emulator answering the TCD1209D driver's sh/f1 with pixel words.
// Latency: data_out/pix_valid register one clk after an f1 rise is seen on the pin.
// Backpressure: none; each accepted f1 rise yields exactly one word, sh rise wins ties.
// Ports: sh/f1 from the driver; pattern_sel/const_val choose the test pattern;
// data_out/pix_valid feed DATA_IN; line_start/line_done/short_line/overrun are
// single-cycle status pulses; line_cnt counts completed lines.
module ccd_line_emulator
  import ccd_emu_pkg::*;
#(
  parameter int                  D_WIDTH     = 12,
  parameter int                  PIX_NUM     = TCD_PIX_NUM,
  parameter int                  DUMMY_LEAD  = TCD_DUMMY_LEAD,
  parameter int                  DUMMY_TRAIL = TCD_DUMMY_TRAIL,
  parameter logic [D_WIDTH-1:0]  DARK_LEVEL  = 'h040,
  parameter logic [15:0]         LFSR_SEED   = 16'hACE1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               sh,
  input  logic               f1,
  input  logic [1:0]         pattern_sel,
  input  logic [D_WIDTH-1:0] const_val,
  output logic [D_WIDTH-1:0] data_out,
  output logic               pix_valid,
  output logic               line_start,
  output logic               line_done,
  output logic               short_line,
  output logic               overrun,
  output logic [15:0]        line_cnt
);

  localparam int TOTAL = DUMMY_LEAD + PIX_NUM + DUMMY_TRAIL;
  localparam int IDX_W = $clog2(TOTAL);

  state_e             state;
  logic [IDX_W-1:0]   idx;
  logic               sh_d, f1_d;
  logic               sh_rise, sh_fall, f1_rise;
  logic               is_active, is_last, step;
  logic [IDX_W-1:0]   pix_idx;
  logic [D_WIDTH-1:0] pat_val;

  // Inputs share our clock, so a single register suffices for edge detection.
  assign sh_rise = sh & ~sh_d;
  assign sh_fall = ~sh & sh_d;
  assign f1_rise = f1 & ~f1_d;

  assign is_active = (idx >= IDX_W'(DUMMY_LEAD)) && (idx < IDX_W'(DUMMY_LEAD + PIX_NUM));
  assign is_last   = (idx == IDX_W'(TOTAL - 1));
  assign pix_idx   = idx - IDX_W'(DUMMY_LEAD);
  assign step      = (state == READ) && f1_rise && !sh_rise && is_active;

  ccd_pattern_gen #(
    .D_WIDTH  (D_WIDTH),
    .IDX_W    (IDX_W),
    .LFSR_SEED(LFSR_SEED)
  ) u_pattern_gen (
    .clk        (clk),
    .resetn     (resetn),
    .pattern_sel(pattern_sel),
    .const_val  (const_val),
    .pix_idx    (pix_idx),
    .step       (step),
    .reload     (sh_rise),
    .pix_val    (pat_val)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // Edge history resets high so a level already high at release is not an edge.
      sh_d       <= 1'b1;
      f1_d       <= 1'b1;
      state      <= IDLE;
      idx        <= '0;
      data_out   <= '0;
      pix_valid  <= 1'b0;
      line_start <= 1'b0;
      line_done  <= 1'b0;
      short_line <= 1'b0;
      overrun    <= 1'b0;
      line_cnt   <= '0;
    end else begin
      sh_d       <= sh;
      f1_d       <= f1;
      pix_valid  <= 1'b0;
      line_start <= 1'b0;
      line_done  <= 1'b0;
      short_line <= 1'b0;
      overrun    <= 1'b0;
      if (sh_rise) begin
        // A new shift gate restarts the line from any state; a coincident f1 edge is dropped.
        state      <= INTEG;
        idx        <= '0;
        line_start <= 1'b1;
        short_line <= (state == READ);
      end else begin
        case (state)
          INTEG: if (sh_fall) state <= READ;
          READ: if (f1_rise) begin
            data_out  <= is_active ? pat_val : DARK_LEVEL;
            pix_valid <= 1'b1;
            if (is_last) begin
              line_done <= 1'b1;
              line_cnt  <= line_cnt + 16'd1;
              state     <= DONE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          DONE: if (f1_rise) begin
            data_out  <= DARK_LEVEL;
            pix_valid <= 1'b1;
            overrun   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ccd_line_emulator.sv
// Scoreboard bench for ccd_line_emulator: stimulus pushes expected words, monitor pops on pix_valid.
module tb_ccd_line_emulator;

  typedef struct {
    logic [11:0] d;
    logic        done;
    logic        ovr;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sh, f1;
  logic [1:0]  pattern_sel;
  logic [11:0] const_val;
  logic [11:0] data_out;
  logic        pix_valid, line_start, line_done, short_line, overrun;
  logic [15:0] line_cnt;

  int total = 0;
  int bad   = 0;
  int cnt_start = 0, cnt_done = 0, cnt_short = 0, cnt_ovr = 0, cnt_pv = 0;

  exp_t        sb[$];
  logic [1:0]  m_pat;
  logic [15:0] m_lfsr;

  ccd_line_emulator dut (
    .clk        (clk),
    .resetn     (resetn),
    .sh         (sh),
    .f1         (f1),
    .pattern_sel(pattern_sel),
    .const_val  (const_val),
    .data_out   (data_out),
    .pix_valid  (pix_valid),
    .line_start (line_start),
    .line_done  (line_done),
    .short_line (short_line),
    .overrun    (overrun),
    .line_cnt   (line_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: compares every presented word against the head of the scoreboard.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (line_start) cnt_start++;
      if (line_done)  cnt_done++;
      if (short_line) cnt_short++;
      if (overrun)    cnt_ovr++;
      if (pix_valid) begin
        exp_t e;
        cnt_pv++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pix: got data=%h with no word expected", data_out);
        end else begin
          e = sb.pop_front();
          if (data_out !== e.d || line_done !== e.done || overrun !== e.ovr) begin
            bad++;
            $display("FAIL pix_word: got data=%h done=%b ovr=%b, want data=%h done=%b ovr=%b",
                     data_out, line_done, overrun, e.d, e.done, e.ovr);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic f1_pulse();
    f1 = 1'b1; tick();
    f1 = 1'b0; tick();
  endtask

  task automatic sh_pulse(input logic [1:0] pat);
    pattern_sel = pat;
    m_pat       = pat;
    m_lfsr      = 16'hACE1;
    sh = 1'b1; tick(); tick();
    sh = 1'b0; tick(); tick();
  endtask

  // Expected word for pixel index i of the current line (index >= 2102 is overrun).
  task automatic push_exp(input int i);
    exp_t e;
    int   p;
    e.done = (i == 2101);
    e.ovr  = (i >= 2102);
    e.d    = 12'h040;
    if (i >= 32 && i < 2080) begin
      p = i - 32;
      case (m_pat)
        2'd0: e.d = p[11:0];
        2'd1: e.d = const_val;
        2'd2: e.d = p[0] ? ~const_val : const_val;
        default: begin
          e.d    = m_lfsr[11:0];
          m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
      endcase
    end
    sb.push_back(e);
  endtask

  task automatic run_pixels(input int n, input int chg_at);
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) pattern_sel = 2'd0;
      push_exp(i);
      f1_pulse();
    end
  endtask

  initial begin
    #5_000_000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    resetn = 1'b0; sh = 1'b0; f1 = 1'b0;
    pattern_sel = 2'd0; const_val = 12'h5A3;
    m_pat = 2'd0; m_lfsr = 16'hACE1;
    tick(); tick(); tick();
    check("rst_data_out", int'(data_out), 0);
    check("rst_pix_valid", int'(pix_valid), 0);
    check("rst_line_cnt", int'(line_cnt), 0);
    check("rst_line_start", int'(line_start), 0);

    // sh already high when reset releases must not open a line.
    sh = 1'b1; resetn = 1'b1;
    tick(); tick(); tick();
    sh = 1'b0; tick(); tick();
    check("no_start_on_high_sh", cnt_start, 0);

    // Nominal ramp line.
    sh_pulse(2'd0);
    run_pixels(2102, -1);
    tick();
    check("ramp_line_cnt", int'(line_cnt), 1);
    check("ramp_done_cnt", cnt_done, 1);

    // Two PRBS lines; second one flips pattern_sel mid-line with no effect.
    sh_pulse(2'd3);
    run_pixels(2102, -1);
    sh_pulse(2'd3);
    run_pixels(2102, 500);
    tick();
    check("prbs_line_cnt", int'(line_cnt), 3);

    // Alternating line cut short at 1000 pixels, then a constant line with 8 extra f1 edges.
    sh_pulse(2'd2);
    run_pixels(1000, -1);
    sh_pulse(2'd1);
    check("short_pulse", cnt_short, 1);
    check("short_line_cnt", int'(line_cnt), 3);
    run_pixels(2110, -1);
    tick();
    check("ovr_count", cnt_ovr, 8);
    check("ovr_line_cnt", int'(line_cnt), 4);
    check("start_count", cnt_start, 5);

    // Collision: sh and f1 rise together, then an f1 pulse while sh is high.
    sh = 1'b1; f1 = 1'b1; tick();
    f1 = 1'b0; tick();
    f1_pulse();
    sh = 1'b0; tick(); tick();
    check("collision_start", cnt_start, 6);
    check("collision_short", cnt_short, 1);
    m_lfsr = 16'hACE1;
    run_pixels(500, -1);

    // Asynchronous reset in the middle of the line.
    #2 resetn = 1'b0;
    #1;
    check("midrst_data_out", int'(data_out), 0);
    check("midrst_line_cnt", int'(line_cnt), 0);
    check("midrst_pix_valid", int'(pix_valid), 0);
    check("midrst_sb_empty", sb.size(), 0);
    tick();
    resetn = 1'b1;
    tick();
    begin
      int pv_before;
      pv_before = cnt_pv;
      for (int k = 0; k < 5; k++) f1_pulse();
      tick();
      check("no_pix_after_rst", cnt_pv, pv_before);
    end
    check("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccd_line_emulator.md
Name: ccd_line_emulator

Overview:
- Synthesizable linear-CCD + AFE emulator. Responds to the shift/transfer clocks produced by the TCD1209D driver (sh, f1) and returns a 12-bit pixel word per f1 period, in place of the AD9945 output.
- Feeds the driver's DATA_IN so the driver → ccd2axis → rows_resize chain can run on hardware and in simulation without a sensor.
- Generates dark dummy pixels plus a selectable test pattern, and reports line-timing errors.

Parameters:
- D_WIDTH, 12, pixel word width.
- PIX_NUM, 2048, active pixels per line.
- DUMMY_LEAD, 32, dark pixels before active pixels.
- DUMMY_TRAIL, 22, dark pixels after active pixels; the line total is 2102, matching driver f_cnt.
- DARK_LEVEL, 12'h040, value output for dummy and overrun pixels.
- LFSR_SEED, 16'hACE1, PRBS seed, reloaded at every line start.

Ports:
- clk, in, 1, system clock; same clock as the driver's sys_clk.
- resetn, in, 1, asynchronous active-low reset.
- sh, in, 1, shift gate from the driver.
- f1, in, 1, phase-1 transfer clock from the driver.
- pattern_sel, in, 2: 0 = ramp, 1 = constant, 2 = alternating, 3 = PRBS16.
- const_val, in, D_WIDTH, value for constant mode; the low half of alternating mode.
- data_out, out, D_WIDTH, pixel word for the driver's DATA_IN.
- pix_valid, out, 1, 1-cycle pulse each time data_out updates.
- line_start, out, 1, 1-cycle pulse on a detected sh rising edge.
- line_done, out, 1, 1-cycle pulse when the last trailing dummy pixel is output.
- short_line, out, 1, 1-cycle pulse when sh rises before the line completed.
- overrun, out, 1, 1-cycle pulse for each f1 edge past the line end.
- line_cnt, out, 16, lines completed since reset; wraps at 16'hFFFF → 0.

Behaviour:
- Reset values: data_out = 0, all pulse outputs = 0, line_cnt = 0, state = IDLE, pixel index = 0, LFSR = LFSR_SEED.
- Input handling: sh and f1 are registered once (sh_d, f1_d). Edges are detected as rising = ~x_d & x. No metastability stage is used, because the inputs are same-clock.
- Outputs are registered. data_out and pix_valid change one clk after the rising edge is seen on the input pin.
- FSM states: IDLE, INTEG, READ, DONE.
  - IDLE: on sh rise → INTEG, idx = 0, line_start pulse, LFSR reloaded.
  - INTEG: f1 edges are ignored while sh = 1. On sh fall → READ.
  - READ: on each f1 rise, output the pixel for idx, pulse pix_valid, then idx + 1.
    - When idx = TOTAL−1 (TOTAL = DUMMY_LEAD + PIX_NUM + DUMMY_TRAIL), also pulse line_done, increment line_cnt, and go to DONE.
  - DONE: each f1 rise outputs DARK_LEVEL with pix_valid and an overrun pulse; idx holds. On sh rise → INTEG, with line_start.
- Regions:
  - idx < DUMMY_LEAD → DARK_LEVEL.
  - The next PIX_NUM indices are active; p = idx − DUMMY_LEAD.
  - The remaining DUMMY_TRAIL indices → DARK_LEVEL.
- Active pixel values:
  - ramp: p[D_WIDTH−1:0], which wraps modulo 2^D_WIDTH.
  - constant: const_val.
  - alternating: const_val when p is even, ~const_val when p is odd.
  - PRBS: LFSR[D_WIDTH−1:0]. The LFSR is x^16+x^14+x^13+x^11+1, Fibonacci form, and advances once per active pixel only.
- pattern_sel is sampled at line_start and held for the whole line. A mid-line change takes effect on the next line.
- sh rise in READ (line not complete):
  - pulse short_line, do not increment line_cnt, restart the line (→ INTEG, idx = 0, line_start).
- Same-cycle sh rise and f1 rise: sh wins. The f1 edge is dropped and no pix_valid is produced.
- sh rise in INTEG (sh glitch low then high without f1): restart the line, no short_line.
- Asynchronous reset mid-line: immediate return to reset values. The first line after release begins only on an sh rising edge; an sh already high at release does not count as an edge.
- Index width: clog2(TOTAL) bits, with no wrap inside a line.

Decomposition:
- Shared package ccd_emu_pkg holds:
  - pattern_sel encodings (PAT_RAMP, PAT_CONST, PAT_ALT, PAT_PRBS);
  - FSM state encodings;
  - the TCD1209D defaults (PIX_NUM, DUMMY_LEAD, DUMMY_TRAIL, TOTAL = 2102).
- One sub-module: ccd_pattern_gen. Inputs are pattern_sel, const_val, pixel index, step and reload; output is the active pixel value. It contains the LFSR.
- The top holds the edge detectors, FSM, counters and status pulses.

Test Plan:
- Nominal ramp: one sh pulse then 2102 f1 pulses, pattern 0 →
  - pixels 0–31 and 2080–2101 = 12'h040;
  - pixel 32 = 0, pixel 2079 = 2047;
  - line_done on the 2102nd pixel; line_cnt = 1.
- PRBS reproducibility: two consecutive lines in pattern 3 → active sequences are identical and the first active word = LFSR_SEED[11:0] (12'hCE1).
- Short line: sh rises after 1000 f1 pulses → short_line pulse, line_cnt unchanged, and the next line's pixel 0 = DARK_LEVEL.
- Overrun: 2110 f1 pulses in one line → exactly 8 overrun pulses, each with data_out = 12'h040.
- Collision: sh and f1 rise in the same cycle → no pix_valid that cycle, idx = 0 afterwards.
- Reset mid-line: resetn low at pixel 500 → all outputs 0 immediately. After release, f1 edges without sh → no pix_valid.
